// File: rtl/frame_dispatch.sv
// frame_dispatch: captures a complete loader frame on frame_ack and streams it
// into the decoder column memory as NCOL Z-bit slices. Writes only proceed
// while the decoder reports idle. A single-cycle dec_start follows the last
// slice. A frame_ack that arrives mid-dispatch is dropped and latches a sticky
// overflow flag.
module frame_dispatch #(
  parameter int FRAME_W = 9216,
  parameter int Z       = 128,
  parameter int NCOL    = 72,
  parameter int ADDR_W  = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] buffer_in,
  input  logic               frame_ack,
  input  logic               dec_idle,
  input  logic               clr_overflow,
  output logic               col_wr_en,
  output logic [ADDR_W-1:0]  col_wr_addr,
  output logic [Z-1:0]       col_wr_data,
  output logic               dec_start,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, WRITE, START} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NCOL - 1);

  state_t                    state;
  logic [ADDR_W-1:0]         idx;
  // Slice-indexed view of the captured frame; slice k is bytes 16k..16k+15.
  logic [NCOL-1:0][Z-1:0]    hold;

  // Dispatch FSM with all outputs registered. busy tracks the state one cycle
  // late so that it lines up with the write/start strobes it covers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      hold        <= '0;
      col_wr_en   <= 1'b0;
      col_wr_addr <= '0;
      col_wr_data <= '0;
      dec_start   <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      col_wr_en <= 1'b0;
      dec_start <= 1'b0;
      busy      <= (state != IDLE);

      // A set in the same cycle as a clear must win.
      if (frame_ack && (state != IDLE)) overflow <= 1'b1;
      else if (clr_overflow)            overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_ack) begin
            hold  <= buffer_in;
            idx   <= '0;
            state <= WRITE;
          end
        end
        WRITE: begin
          // Stall with idx/addr/data frozen while the decoder owns the memory.
          if (dec_idle) begin
            col_wr_en   <= 1'b1;
            col_wr_addr <= idx;
            col_wr_data <= hold[idx];
            if (idx == LAST) state <= START;
            else             idx   <= idx + 1'b1;
          end
        end
        START: begin
          dec_start <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
